bsg_cache_nb_tag_scoreboard: RTL and testbench

Synthesizable, self-checking scoreboard for the non-blocking cache's tag-maintenance path. It snoops accepted request packets and accepted responses at the cache boundary. It keeps a shadow copy of the tag array and a per-id table of expected responses, which allows out-of-order completion. Mismatches, unexpected responses and duplicate in-flight ids are reported on sticky error outputs rather than simulator fatals, so the block can be used in emulation as well as in the regression bench.

---
 rtl/bsg_cache_nb_tag_scoreboard.sv | 187 ++++++++++++++++++
 tb/tb_bsg_cache_nb_tag_scoreboard.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_nb_tag_scoreboard.sv
// Snoops the non-blocking cache boundary and checks tag-op responses against a shadow tag array.
// cache_pkt_i layout, MSB first: {opcode[5:0], addr, data, src_id}. Errors are sticky; only the first is captured.
module bsg_cache_nb_tag_scoreboard #(
    parameter int src_id_width_p        = 4,
    parameter int data_width_p          = 32,
    parameter int addr_width_p          = 32,
    parameter int ways_p                = 2,
    parameter int sets_p                = 8,
    parameter int tag_width_p           = 20,
    parameter int block_size_in_words_p = 8,
    parameter int count_width_p         = 16,
    parameter int check_id_zero_p       = 0,
    localparam int pkt_width_lp = 6 + addr_width_p + data_width_p + src_id_width_p
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      en_i,
    input  logic                      req_v_i,
    input  logic                      req_yumi_i,
    input  logic [pkt_width_lp-1:0]   cache_pkt_i,
    input  logic                      resp_v_i,
    input  logic                      resp_yumi_i,
    input  logic [data_width_p-1:0]   resp_data_i,
    input  logic [src_id_width_p-1:0] resp_src_id_i,
    output logic                      error_o,
    output logic [1:0]                error_code_o,
    output logic [src_id_width_p-1:0] error_id_o,
    output logic [data_width_p-1:0]   error_expected_o,
    output logic [data_width_p-1:0]   error_actual_o,
    output logic [src_id_width_p:0]   pending_o,
    output logic                      idle_o,
    output logic [count_width_p-1:0]  match_count_o,
    output logic [count_width_p-1:0]  error_count_o
);

    localparam logic [5:0] op_tagst = 6'b010000;
    localparam logic [5:0] op_taglv = 6'b010010;
    localparam logic [5:0] op_tagla = 6'b010011;

    localparam int block_off_lp = $clog2(data_width_p/8) + $clog2(block_size_in_words_p);
    localparam int lg_sets_lp   = (sets_p > 1) ? $clog2(sets_p) : 1;
    localparam int lg_ways_lp   = (ways_p > 1) ? $clog2(ways_p) : 1;
    localparam int num_sets_lp  = 1 << lg_sets_lp;
    localparam int num_ways_lp  = 1 << lg_ways_lp;
    localparam int num_ids_lp   = 1 << src_id_width_p;
    localparam int la_width_lp  = tag_width_p + lg_sets_lp + block_off_lp;

    logic [5:0]                req_opcode;
    logic [addr_width_p-1:0]   req_addr;
    logic [data_width_p-1:0]   req_data;
    logic [src_id_width_p-1:0] req_id;
    logic [lg_sets_lp-1:0]     req_index;
    logic [lg_ways_lp-1:0]     req_way;

    assign req_opcode = cache_pkt_i[pkt_width_lp-1 -: 6];
    assign req_addr   = cache_pkt_i[src_id_width_p+data_width_p +: addr_width_p];
    assign req_data   = cache_pkt_i[src_id_width_p +: data_width_p];
    assign req_id     = cache_pkt_i[src_id_width_p-1:0];
    assign req_index  = req_addr[block_off_lp +: lg_sets_lp];
    assign req_way    = req_addr[block_off_lp+lg_sets_lp +: lg_ways_lp];

    logic [tag_width_p-1:0] shadow_tag_r   [num_ways_lp][num_sets_lp];
    logic                   shadow_valid_r [num_ways_lp][num_sets_lp];
    logic                   shadow_lock_r  [num_ways_lp][num_sets_lp];

    logic [num_ids_lp-1:0]   tbl_v_r;
    logic [num_ids_lp-1:0]   tbl_cmp_r;
    logic [data_width_p-1:0] tbl_exp_r [num_ids_lp];

    logic req_fire, resp_fire;
    assign req_fire  = en_i & req_v_i & req_yumi_i
                     & ((check_id_zero_p != 0) | (req_id != '0));
    assign resp_fire = en_i & resp_v_i & resp_yumi_i
                     & ((check_id_zero_p != 0) | (resp_src_id_i != '0));

    // Expectation is formed from the shadow as it stands before this edge.
    logic [la_width_lp+data_width_p-1:0] la_full;
    logic                                req_cmp;
    logic [data_width_p-1:0]             req_exp;

    assign la_full = {{data_width_p{1'b0}}, shadow_tag_r[req_way][req_index],
                      req_index, {block_off_lp{1'b0}}};

    always_comb begin
        req_cmp = 1'b0;
        req_exp = '0;
        case (req_opcode)
            op_tagst: req_cmp = 1'b1;
            op_taglv: begin
                req_cmp = 1'b1;
                req_exp = data_width_p'({shadow_lock_r[req_way][req_index],
                                         shadow_valid_r[req_way][req_index]});
            end
            op_tagla: begin
                req_cmp = 1'b1;
                req_exp = la_full[data_width_p-1:0];
            end
            default: ;
        endcase
    end

    logic resp_hit, retire, resp_unexp, resp_mismatch, resp_match, resp_err, dup, alloc_new;
    assign resp_hit      = tbl_v_r[resp_src_id_i];
    assign retire        = resp_fire & resp_hit;
    assign resp_unexp    = resp_fire & ~resp_hit;
    assign resp_mismatch = retire & tbl_cmp_r[resp_src_id_i]
                         & (resp_data_i != tbl_exp_r[resp_src_id_i]);
    assign resp_match    = retire & ~resp_mismatch;
    assign resp_err      = resp_unexp | resp_mismatch;
    // A same-cycle retire of the same id frees the slot before the new allocation.
    assign dup           = req_fire & tbl_v_r[req_id] & ~(retire & (resp_src_id_i == req_id));
    assign alloc_new     = req_fire & ~dup;

    logic [src_id_width_p:0]  pending_r, pending_next;
    logic [count_width_p-1:0] match_cnt_r, err_cnt_r, match_cnt_next, err_cnt_next;
    logic [count_width_p:0]   match_sum, err_sum;
    logic [1:0]               num_err;

    assign num_err        = {1'b0, resp_err} + {1'b0, dup};
    assign pending_next   = pending_r + (src_id_width_p+1)'(alloc_new)
                                      - (src_id_width_p+1)'(retire);
    assign match_sum      = {1'b0, match_cnt_r} + (count_width_p+1)'(resp_match);
    assign err_sum        = {1'b0, err_cnt_r} + (count_width_p+1)'(num_err);
    assign match_cnt_next = match_sum[count_width_p] ? '1 : match_sum[count_width_p-1:0];
    assign err_cnt_next   = err_sum[count_width_p] ? '1 : err_sum[count_width_p-1:0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tbl_v_r   <= '0;
            tbl_cmp_r <= '0;
            for (int i = 0; i < num_ids_lp; i++) tbl_exp_r[i] <= '0;
        end else begin
            if (retire) tbl_v_r[resp_src_id_i] <= 1'b0;
            if (req_fire) begin
                tbl_v_r[req_id]   <= 1'b1;
                tbl_cmp_r[req_id] <= req_cmp;
                tbl_exp_r[req_id] <= req_exp;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int w = 0; w < num_ways_lp; w++) begin
                for (int s = 0; s < num_sets_lp; s++) begin
                    shadow_tag_r[w][s]   <= '0;
                    shadow_valid_r[w][s] <= 1'b0;
                    shadow_lock_r[w][s]  <= 1'b0;
                end
            end
        end else if (req_fire && (req_opcode == op_tagst)) begin
            shadow_tag_r[req_way][req_index]   <= req_data[tag_width_p-1:0];
            shadow_valid_r[req_way][req_index] <= req_data[data_width_p-1];
            shadow_lock_r[req_way][req_index]  <= req_data[data_width_p-2];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_r        <= '0;
            match_cnt_r      <= '0;
            err_cnt_r        <= '0;
            error_o          <= 1'b0;
            error_code_o     <= 2'd0;
            error_id_o       <= '0;
            error_expected_o <= '0;
            error_actual_o   <= '0;
        end else begin
            pending_r   <= pending_next;
            match_cnt_r <= match_cnt_next;
            err_cnt_r   <= err_cnt_next;
            if (!error_o && (resp_err || dup)) begin
                error_o          <= 1'b1;
                error_code_o     <= resp_mismatch ? 2'd1 : (resp_unexp ? 2'd2 : 2'd3);
                error_id_o       <= resp_err ? resp_src_id_i : req_id;
                error_expected_o <= resp_mismatch ? tbl_exp_r[resp_src_id_i] : '0;
                error_actual_o   <= resp_mismatch ? resp_data_i : '0;
            end
        end
    end

    assign pending_o     = pending_r;
    assign idle_o        = (pending_r == '0);
    assign match_count_o = match_cnt_r;
    assign error_count_o = err_cnt_r;

endmodule

// File: tb/tb_bsg_cache_nb_tag_scoreboard.sv
// Bench for bsg_cache_nb_tag_scoreboard: directed tag-op scenarios plus randomized traffic
// checked against a table-of-expectations model with small counters to reach saturation.
module tb_bsg_cache_nb_tag_scoreboard;

    localparam int SRC_W = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int CNT_W = 4;
    localparam int PKT_W = 6 + AW + DW + SRC_W;
    localparam logic [5:0] OP_TAGST = 6'b010000;
    localparam logic [5:0] OP_TAGLV = 6'b010010;
    localparam logic [5:0] OP_TAGLA = 6'b010011;
    localparam logic [5:0] OP_LW    = 6'b000010;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic             en_i, req_v_i, req_yumi_i, resp_v_i, resp_yumi_i;
    logic [5:0]       d_op;
    logic [AW-1:0]    d_addr;
    logic [DW-1:0]    d_data;
    logic [SRC_W-1:0] d_id;
    logic [PKT_W-1:0] cache_pkt_i;
    logic [DW-1:0]    resp_data_i;
    logic [SRC_W-1:0] resp_src_id_i;
    logic             error_o, idle_o;
    logic [1:0]       error_code_o;
    logic [SRC_W-1:0] error_id_o;
    logic [DW-1:0]    error_expected_o, error_actual_o;
    logic [SRC_W:0]   pending_o;
    logic [CNT_W-1:0] match_count_o, error_count_o;

    assign cache_pkt_i = {d_op, d_addr, d_data, d_id};

    bsg_cache_nb_tag_scoreboard #(
        .src_id_width_p(SRC_W), .data_width_p(DW), .addr_width_p(AW),
        .ways_p(2), .sets_p(8), .tag_width_p(20), .block_size_in_words_p(8),
        .count_width_p(CNT_W), .check_id_zero_p(0)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i),
        .req_v_i(req_v_i), .req_yumi_i(req_yumi_i), .cache_pkt_i(cache_pkt_i),
        .resp_v_i(resp_v_i), .resp_yumi_i(resp_yumi_i),
        .resp_data_i(resp_data_i), .resp_src_id_i(resp_src_id_i),
        .error_o(error_o), .error_code_o(error_code_o), .error_id_o(error_id_o),
        .error_expected_o(error_expected_o), .error_actual_o(error_actual_o),
        .pending_o(pending_o), .idle_o(idle_o),
        .match_count_o(match_count_o), .error_count_o(error_count_o)
    );

    always #5 clk_i = ~clk_i;

    int tests  = 0;
    int failed = 0;

    // Reference model: outstanding expectations per id and the tag array as software sees it.
    bit          m_v   [16];
    bit          m_cmp [16];
    logic [31:0] m_exp [16];
    logic [19:0] sh_tag [2][8];
    bit          sh_v   [2][8];
    bit          sh_l   [2][8];
    bit          m_err;
    int          m_code, m_eid, m_match, m_ecnt;
    logic [31:0] m_eexp, m_eact;

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < 16; i++) n += m_v[i];
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin m_v[i] = 0; m_cmp[i] = 0; m_exp[i] = 0; end
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin sh_tag[w][s] = 0; sh_v[w][s] = 0; sh_l[w][s] = 0; end
        m_err = 0; m_code = 0; m_eid = 0; m_match = 0; m_ecnt = 0; m_eexp = 0; m_eact = 0;
    endtask

    // Block offset is 5 bits (4-byte words, 8 words), set is next 3 bits, way is bit 8.
    task automatic model_step();
        bit rf, sf, rerr, dupe, cmp;
        int w, s, code;
        logic [31:0] e, t;
        rerr = 0; dupe = 0; code = 0; e = 0;
        rf = en_i && req_v_i && req_yumi_i && (d_id != 0);
        sf = en_i && resp_v_i && resp_yumi_i && (resp_src_id_i != 0);
        if (sf) begin
            if (!m_v[resp_src_id_i]) begin
                rerr = 1; code = 2;
            end else begin
                if (m_cmp[resp_src_id_i] && resp_data_i != m_exp[resp_src_id_i]) begin
                    rerr = 1; code = 1;
                end else if (m_match < 15) m_match++;
                if (!m_err && rerr) begin m_eexp = m_exp[resp_src_id_i]; m_eact = resp_data_i; end
                m_v[resp_src_id_i] = 0;
            end
            if (!m_err && rerr) begin
                m_err = 1; m_code = code; m_eid = resp_src_id_i;
                if (code == 2) begin m_eexp = 0; m_eact = 0; end
            end
        end
        if (rf) begin
            w = d_addr[8]; s = d_addr[7:5]; cmp = 1;
            t = 32'(sh_tag[w][s]);
            if (d_op == OP_TAGST)      e = 0;
            else if (d_op == OP_TAGLV) e = 2 * sh_l[w][s] + sh_v[w][s];
            else if (d_op == OP_TAGLA) e = t * 256 + s * 32;
            else begin e = 0; cmp = 0; end
            dupe = m_v[d_id];
            m_v[d_id] = 1; m_cmp[d_id] = cmp; m_exp[d_id] = e;
            if (d_op == OP_TAGST) begin
                sh_tag[w][s] = d_data[19:0]; sh_v[w][s] = d_data[31]; sh_l[w][s] = d_data[30];
            end
            if (!m_err && dupe) begin
                m_err = 1; m_code = 3; m_eid = d_id; m_eexp = 0; m_eact = 0;
            end
        end
        m_ecnt = m_ecnt + rerr + dupe;
        if (m_ecnt > 15) m_ecnt = 15;
    endtask

    task automatic cycle(input bit rq, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] id,
                         input bit rs, input logic [3:0] rid, input logic [31:0] rdata);
        req_v_i = rq; req_yumi_i = rq; d_op = op; d_addr = addr; d_data = data; d_id = id;
        resp_v_i = rs; resp_yumi_i = rs; resp_src_id_i = rid; resp_data_i = rdata;
        @(posedge clk_i);
        model_step();
        #1;
        req_v_i = 0; req_yumi_i = 0; resp_v_i = 0; resp_yumi_i = 0;
    endtask

    task automatic req(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] id);
        cycle(1, op, addr, data, id, 0, 0, 0);
    endtask

    task automatic resp(input logic [3:0] rid, input logic [31:0] rdata);
        cycle(0, OP_LW, 0, 0, 0, 1, rid, rdata);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 0; en_i = 1;
        req_v_i = 0; req_yumi_i = 0; resp_v_i = 0; resp_yumi_i = 0;
        @(negedge clk_i);
        reset_n_i = 1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n_i = 0; en_i = 1;
        req_v_i = 0; req_yumi_i = 0; resp_v_i = 0; resp_yumi_i = 0;
        d_op = 0; d_addr = 0; d_data = 0; d_id = 0; resp_data_i = 0; resp_src_id_i = 0;
        model_reset();
        #3;
        tests++;
        if (error_o !== 0 || error_code_o !== 0 || pending_o !== 0 || idle_o !== 1 ||
            match_count_o !== 0 || error_count_o !== 0 || error_id_o !== 0) begin
            failed++;
            $display("FAIL reset_state: err=%b code=%0d pend=%0d idle=%b match=%0d ecnt=%0d required 0/0/0/1/0/0",
                     error_o, error_code_o, pending_o, idle_o, match_count_o, error_count_o);
        end
        @(negedge clk_i);
        reset_n_i = 1;
    endtask

    task automatic test_tag_ops();
        do_reset();
        req(OP_TAGST, 32'h160, 32'h8000_002A, 1);
        req(OP_TAGLA, 32'h160, 0, 2);
        req(OP_TAGLV, 32'h160, 0, 3);
        tests++;
        if (pending_o !== 3) begin
            failed++; $display("FAIL tag_ops_pending: got %0d required 3", pending_o);
        end
        resp(1, 32'h0);
        resp(2, 32'h2A60);
        resp(3, 32'h1);
        tests++;
        if (match_count_o !== 3 || error_o !== 0 || idle_o !== 1) begin
            failed++;
            $display("FAIL tag_ops_result: match=%0d err=%b idle=%b required 3/0/1",
                     match_count_o, error_o, idle_o);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        req(OP_TAGST, 32'h160, 32'h8000_002A, 1);
        resp(1, 0);
        req(OP_TAGLV, 32'h160, 0, 5);
        resp(5, 32'h2);
        tests++;
        if (error_o !== 1 || error_code_o !== 1 || error_id_o !== 5 ||
            error_expected_o !== 32'h1 || error_actual_o !== 32'h2 || error_count_o !== 1) begin
            failed++;
            $display("FAIL mismatch: err=%b code=%0d id=%0d exp=%h act=%h ecnt=%0d required 1/1/5/1/2/1",
                     error_o, error_code_o, error_id_o, error_expected_o, error_actual_o, error_count_o);
        end
        tests++;
        if (pending_o !== 0) begin
            failed++; $display("FAIL mismatch_retire: pending %0d required 0", pending_o);
        end
    endtask

    task automatic test_unexpected();
        do_reset();
        req(OP_LW, 32'h40, 0, 3);
        resp(7, 32'hDEAD_BEEF);
        tests++;
        if (error_o !== 1 || error_code_o !== 2 || error_id_o !== 7 || pending_o !== 1 ||
            error_expected_o !== 0 || error_actual_o !== 0) begin
            failed++;
            $display("FAIL unexpected: err=%b code=%0d id=%0d pend=%0d exp=%h act=%h required 1/2/7/1/0/0",
                     error_o, error_code_o, error_id_o, pending_o, error_expected_o, error_actual_o);
        end
    endtask

    task automatic test_duplicate();
        do_reset();
        req(OP_LW, 32'h40, 0, 4);
        req(OP_LW, 32'h80, 0, 4);
        tests++;
        if (error_code_o !== 3 || error_id_o !== 4 || pending_o !== 1 || error_count_o !== 1) begin
            failed++;
            $display("FAIL duplicate: code=%0d id=%0d pend=%0d ecnt=%0d required 3/4/1/1",
                     error_code_o, error_id_o, pending_o, error_count_o);
        end
        do_reset();
        req(OP_LW, 32'h40, 0, 4);
        cycle(1, OP_LW, 32'h80, 0, 4, 1, 4, 32'h1234);
        tests++;
        if (error_o !== 0 || pending_o !== 1 || match_count_o !== 1) begin
            failed++;
            $display("FAIL same_id_swap: err=%b pend=%0d match=%0d required 0/1/1",
                     error_o, pending_o, match_count_o);
        end
    endtask

    task automatic test_reverse_order();
        logic [5:0]  ops   [8] = '{OP_TAGST, OP_TAGLA, OP_TAGLV, OP_LW, OP_TAGLA, OP_TAGST, OP_TAGLV, OP_LW};
        logic [31:0] addrs [8] = '{32'h40, 32'h40, 32'h40, 32'h44, 32'h1E0, 32'h1E0, 32'h1E0, 32'h8};
        logic [31:0] datas [8] = '{32'hC001_2345, 0, 0, 0, 0, 32'h8000_0777, 0, 0};
        bit ok;
        do_reset();
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            req(ops[i], addrs[i], datas[i], 4'(i + 1));
            if (pending_o !== 5'(i + 1)) ok = 0;
        end
        tests++;
        if (!ok) begin failed++; $display("FAIL reverse_fill: pending %0d required 8", pending_o); end
        ok = 1;
        for (int i = 8; i >= 1; i--) begin
            resp(4'(i), m_cmp[i] ? m_exp[i] : $urandom);
            if (pending_o !== 5'(i - 1)) ok = 0;
        end
        tests++;
        if (!ok || idle_o !== 1 || error_o !== 0 || match_count_o !== 8) begin
            failed++;
            $display("FAIL reverse_drain: pend=%0d idle=%b err=%b code=%0d match=%0d required 0/1/0/-/8",
                     pending_o, idle_o, error_o, error_code_o, match_count_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req(OP_LW, 32'h0, 0, 1);
        req(OP_LW, 32'h0, 0, 2);
        req(OP_LW, 32'h0, 0, 3);
        req(OP_LW, 32'h0, 0, 3);
        tests++;
        if (pending_o !== 3 || error_o !== 1) begin
            failed++; $display("FAIL pre_reset: pend=%0d err=%b required 3/1", pending_o, error_o);
        end
        #2 reset_n_i = 0;
        #1;
        tests++;
        if (pending_o !== 0 || idle_o !== 1 || error_o !== 0 || error_code_o !== 0 || error_count_o !== 0) begin
            failed++;
            $display("FAIL async_clear: pend=%0d idle=%b err=%b code=%0d ecnt=%0d required 0/1/0/0/0",
                     pending_o, idle_o, error_o, error_code_o, error_count_o);
        end
        #2 reset_n_i = 1;
        model_reset();
        resp(2, 0);
        tests++;
        if (error_code_o !== 2 || error_id_o !== 2 || pending_o !== 0) begin
            failed++;
            $display("FAIL stale_resp: code=%0d id=%0d pend=%0d required 2/2/0", error_code_o, error_id_o, pending_o);
        end
        do_reset();
        req(OP_TAGST, 32'h20, 32'h8000_0001, 0);
        resp(0, 32'h5);
        req(OP_TAGLV, 32'h20, 0, 6);
        resp(6, 32'h0);
        tests++;
        if (error_o !== 0 || pending_o !== 0 || match_count_o !== 1) begin
            failed++;
            $display("FAIL id_zero_ignored: err=%b pend=%0d match=%0d required 0/0/1", error_o, pending_o, match_count_o);
        end
    endtask

    task automatic test_random();
        int live [$];
        logic [5:0] opsel [4] = '{OP_TAGST, OP_TAGLA, OP_TAGLV, OP_LW};
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en_i       = ($urandom_range(0, 9) != 0);
            req_v_i    = $urandom_range(0, 1);
            req_yumi_i = req_v_i & ($urandom_range(0, 4) != 0);
            d_op   = opsel[$urandom_range(0, 3)];
            d_addr = {$urandom} & 32'hFFFF_FFE0;
            d_data = $urandom;
            d_id   = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            live.delete();
            for (int i = 0; i < 16; i++) if (m_v[i]) live.push_back(i);
            resp_v_i    = $urandom_range(0, 1);
            resp_yumi_i = resp_v_i & ($urandom_range(0, 4) != 0);
            if (live.size() > 0 && $urandom_range(0, 4) != 0) begin
                resp_src_id_i = 4'(live[$urandom_range(0, live.size() - 1)]);
                resp_data_i   = ($urandom_range(0, 7) == 0) ? $urandom : m_exp[resp_src_id_i];
            end else begin
                resp_src_id_i = 4'($urandom_range(0, 15));
                resp_data_i   = $urandom;
            end
            @(posedge clk_i);
            model_step();
            #1;
            tests++;
            if (error_o !== m_err || error_code_o !== 2'(m_code) || error_id_o !== 4'(m_eid) ||
                error_expected_o !== m_eexp || error_actual_o !== m_eact ||
                pending_o !== 5'(m_pending()) || idle_o !== (m_pending() == 0) ||
                match_count_o !== 4'(m_match) || error_count_o !== 4'(m_ecnt)) begin
                failed++;
                $display("FAIL random_c%0d: err=%b/%b code=%0d/%0d id=%0d/%0d exp=%h/%h act=%h/%h pend=%0d/%0d match=%0d/%0d ecnt=%0d/%0d (got/required)",
                         c, error_o, m_err, error_code_o, m_code, error_id_o, m_eid,
                         error_expected_o, m_eexp, error_actual_o, m_eact,
                         pending_o, m_pending(), match_count_o, m_match, error_count_o, m_ecnt);
            end
        end
        en_i = 1; req_v_i = 0; req_yumi_i = 0; resp_v_i = 0; resp_yumi_i = 0;
    endtask

    initial begin
        test_reset();
        test_tag_ops();
        test_mismatch();
        test_unexpected();
        test_duplicate();
        test_reverse_order();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
